// File: rtl/ga_generation_scheduler.sv
// ga_generation_scheduler: sequences one GA generation around the population
// sorter. It gathers fitness distances, launches the sort, streams the elite
// parent indices to the breeder, and counts generations until the generation
// limit or a perfect individual ends the run.
module ga_generation_scheduler #(
   parameter int POP          = 50,
   parameter int DIST_W       = 12,
   parameter int IDX_W        = 6,
   parameter int ELITE        = 10,
   parameter int MAX_GEN      = 200,
   parameter int SORT_TIMEOUT = 127
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  fit_valid,
   input  logic [IDX_W-1:0]      fit_index,
   input  logic [DIST_W-1:0]     fit_dist,
   output logic                  eval_start,
   output logic                  sort_start,
   output logic [POP*DIST_W-1:0] sort_in,
   input  logic                  sort_done,
   input  logic [POP*IDX_W-1:0]  sort_sorted,
   output logic                  par_valid,
   input  logic                  par_ready,
   output logic [IDX_W-1:0]      par_index,
   output logic [7:0]            gen_count,
   output logic [IDX_W-1:0]      best_index,
   output logic [DIST_W-1:0]     best_dist,
   output logic                  busy,
   output logic                  done,
   output logic                  err_index,
   output logic                  err_timeout
);

   localparam int TW = (SORT_TIMEOUT < 2) ? 1 : $clog2(SORT_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, COLLECT, SORT, EMIT, CHECK, DONE, FAULT} state_t;

   state_t                     state, state_nxt;
   logic [POP-1:0]             mask_q;
   logic [POP-1:0]             mask_set;
   logic [POP-1:0]             mask_after;
   logic [POP-1:0][DIST_W-1:0] dist_q;
   logic [POP-1:0][IDX_W-1:0]  sorted_q;
   logic [IDX_W-1:0]           k_q;
   logic [TW-1:0]              tcnt_q;
   logic [IDX_W-1:0]           slot0;
   logic [7:0]                 gen_inc;
   logic                       fit_in_range;
   logic                       fit_ok;
   logic                       k_last;
   logic                       timed_out;
   logic                       finish;

   // The distance store doubles as the sorter input bus; it only changes in
   // COLLECT, so it is naturally stable for the whole SORT phase.
   assign sort_in      = dist_q;
   assign slot0        = sort_sorted[IDX_W-1:0];
   assign fit_in_range = 32'(fit_index) < POP;
   assign fit_ok       = (state == COLLECT) && fit_valid && fit_in_range;
   assign mask_set     = fit_ok ? ({{(POP-1){1'b0}}, 1'b1} << fit_index) : '0;
   assign mask_after   = mask_q | mask_set;
   assign k_last       = (k_q == IDX_W'(ELITE - 1));
   assign timed_out    = (tcnt_q == TW'(SORT_TIMEOUT));
   assign gen_inc      = (gen_count == 8'hFF) ? 8'hFF : gen_count + 8'd1;
   assign finish       = (gen_inc == 8'(MAX_GEN)) || (best_dist == '0);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt  = state;
      sort_start = 1'b0;
      par_valid  = 1'b0;
      par_index  = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:    if (run) state_nxt = COLLECT;
         COLLECT: begin
            busy = 1'b1;
            // A write landing in the completing cycle is already in mask_after.
            if (&mask_after) state_nxt = SORT;
         end
         SORT: begin
            busy       = 1'b1;
            sort_start = (tcnt_q == '0);
            if (sort_done)      state_nxt = EMIT;
            else if (timed_out) state_nxt = FAULT;
         end
         EMIT: begin
            busy      = 1'b1;
            par_valid = 1'b1;
            par_index = sorted_q[k_q];
            if (par_ready && k_last) state_nxt = CHECK;
         end
         CHECK: begin
            busy      = 1'b1;
            state_nxt = finish ? DONE : COLLECT;
         end
         DONE: begin
            done = 1'b1;
            if (!run) state_nxt = IDLE;
         end
         FAULT:   state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: fitness capture, sort bookkeeping, emit index, generation count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q      <= '0;
         dist_q      <= '0;
         sorted_q    <= '0;
         k_q         <= '0;
         tcnt_q      <= '0;
         gen_count   <= '0;
         best_index  <= '0;
         best_dist   <= '0;
         err_index   <= 1'b0;
         err_timeout <= 1'b0;
         eval_start  <= 1'b0;
      end else begin
         // One-cycle pulse in the first COLLECT cycle of every evaluation pass.
         eval_start <= (state_nxt == COLLECT) && (state != COLLECT);
         tcnt_q     <= (state == SORT) ? tcnt_q + TW'(1) : '0;
         case (state)
            IDLE: if (run) begin
               mask_q      <= '0;
               gen_count   <= '0;
               err_index   <= 1'b0;
               err_timeout <= 1'b0;
            end
            COLLECT: begin
               mask_q <= mask_after;
               if (fit_ok) dist_q[fit_index] <= fit_dist;
               if (fit_valid && !fit_in_range) err_index <= 1'b1;
            end
            SORT: begin
               // sort_sorted is only meaningful in the sort_done cycle.
               if (sort_done) begin
                  sorted_q   <= sort_sorted;
                  best_index <= slot0;
                  best_dist  <= dist_q[slot0];
                  k_q        <= '0;
               end else if (timed_out) begin
                  err_timeout <= 1'b1;
               end
            end
            EMIT: if (par_ready) k_q <= k_last ? '0 : k_q + IDX_W'(1);
            CHECK: begin
               gen_count <= gen_inc;
               if (!finish) mask_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ga_generation_scheduler.sv
// tb_ga_generation_scheduler: directed bench with a sorting model and a
// scoreboard of expected parent indices, drained as the breeder accepts them.
module tb_ga_generation_scheduler;

   localparam int POP   = 50;
   localparam int DW    = 12;
   localparam int IW    = 6;
   localparam int ELITE = 10;
   localparam int MAXG  = 3;
   localparam int STO   = 127;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              run = 1'b0;
   logic              fit_valid = 1'b0;
   logic [IW-1:0]     fit_index = '0;
   logic [DW-1:0]     fit_dist = '0;
   logic              eval_start, sort_start;
   logic [POP*DW-1:0] sort_in;
   logic              sort_done = 1'b0;
   logic [POP*IW-1:0] sort_sorted = '0;
   logic              par_valid;
   logic              par_ready = 1'b0;
   logic [IW-1:0]     par_index;
   logic [7:0]        gen_count;
   logic [IW-1:0]     best_index;
   logic [DW-1:0]     best_dist;
   logic              busy, done, err_index, err_timeout;

   int checks = 0;
   int errors = 0;
   int ev_cnt = 0;
   int ss_cnt = 0;
   int mdl[POP];
   int ord[POP];
   int expq[$];

   always #5 clk = ~clk;

   ga_generation_scheduler #(
      .POP(POP), .DIST_W(DW), .IDX_W(IW), .ELITE(ELITE),
      .MAX_GEN(MAXG), .SORT_TIMEOUT(STO)
   ) dut (
      .clk(clk), .reset(reset), .run(run),
      .fit_valid(fit_valid), .fit_index(fit_index), .fit_dist(fit_dist),
      .eval_start(eval_start), .sort_start(sort_start), .sort_in(sort_in),
      .sort_done(sort_done), .sort_sorted(sort_sorted),
      .par_valid(par_valid), .par_ready(par_ready), .par_index(par_index),
      .gen_count(gen_count), .best_index(best_index), .best_dist(best_dist),
      .busy(busy), .done(done), .err_index(err_index), .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [POP*DW-1:0] obs, input logic [POP*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All sampling and driving happens on the falling edge.
   task automatic tick();
      @(negedge clk);
      if (eval_start) ev_cnt++;
      if (sort_start) ss_cnt++;
   endtask

   task automatic send(input int idx, input int d);
      fit_valid = 1'b1;
      fit_index = idx[IW-1:0];
      fit_dist  = d[DW-1:0];
      if (idx < POP) mdl[idx] = d;
      tick();
      fit_valid = 1'b0;
   endtask

   function automatic logic [POP*DW-1:0] exp_bus();
      logic [POP*DW-1:0] r;
      r = '0;
      for (int i = 0; i < POP; i++) r[i*DW +: DW] = DW'(mdl[i]);
      return r;
   endfunction

   // Reference sorter: ascending distance, ties broken by lower index.
   task automatic build_order();
      int t;
      for (int i = 0; i < POP; i++) ord[i] = i;
      for (int i = 1; i < POP; i++)
         for (int j = i; j > 0; j--)
            if (mdl[ord[j]] < mdl[ord[j-1]]) begin
               t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
            end
   endtask

   // Called in the first SORT cycle; answers after lat cycles.
   task automatic sort_respond(input string tag, input int lat, input int ss_base);
      chk({tag, "_sort_start"}, sort_start, 1);
      chkw({tag, "_sort_in"}, sort_in, exp_bus());
      build_order();
      for (int i = 0; i < lat; i++) tick();
      chk({tag, "_sort_once"}, ss_cnt, ss_base + 1);
      for (int k = 0; k < POP; k++) sort_sorted[k*IW +: IW] = IW'(ord[k]);
      for (int k = 0; k < ELITE; k++) expq.push_back(ord[k]);
      sort_done = 1'b1;
      tick();
      sort_done = 1'b0;
      for (int k = 0; k < POP; k++) sort_sorted[k*IW +: IW] = IW'($urandom_range(0, POP-1));
      chk({tag, "_best_index"}, best_index, ord[0]);
      chk({tag, "_best_dist"}, best_dist, mdl[ord[0]]);
   endtask

   // Drains the scoreboard with a repeating 4-cycle par_ready pattern.
   task automatic emit(input string tag, input logic [3:0] pat, output int cycles);
      int            xfers;
      int            n;
      int            e;
      logic          stalled;
      logic [IW-1:0] held;
      xfers = 0; n = 0; stalled = 1'b0; held = '0;
      while (xfers < ELITE && n < 200) begin
         if (stalled) chk({tag, "_par_hold"}, par_index, held);
         par_ready = pat[n % 4];
         stalled = 1'b0;
         if (par_valid && par_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : -1;
            chk({tag, "_par_index"}, par_index, e);
            xfers++;
         end else if (par_valid) begin
            stalled = 1'b1;
            held = par_index;
         end
         tick();
         n++;
      end
      par_ready = 1'b0;
      cycles = n;
      chk({tag, "_xfers"}, xfers, ELITE);
      chk({tag, "_par_valid_off"}, par_valid, 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_eval_start"}, eval_start, 0);
      chk({tag, "_sort_start"}, sort_start, 0);
      chkw({tag, "_sort_in"}, sort_in, '0);
      chk({tag, "_par_valid"}, par_valid, 0);
      chk({tag, "_par_index"}, par_index, 0);
      chk({tag, "_gen_count"}, gen_count, 0);
      chk({tag, "_best_index"}, best_index, 0);
      chk({tag, "_best_dist"}, best_dist, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err_index"}, err_index, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   initial begin
      int cyc;
      int base;
      int n;
      int perm[$];
      int t;
      int r;

      for (int i = 0; i < POP; i++) mdl[i] = 0;
      repeat (3) tick();
      check_zero("reset");
      reset = 1'b0;
      tick();

      // Generation 1: in-order distances, breeder always ready.
      run = 1'b1;
      tick();
      chk("g1_eval_start", eval_start, 1);
      chk("g1_busy", busy, 1);
      base = ss_cnt;
      for (int i = 0; i < POP; i++) send(i, 100 + i);
      sort_respond("g1", 3, base);
      emit("g1", 4'b1111, cyc);
      chk("g1_emit_cycles", cyc, ELITE);
      tick();
      chk("g1_gen_count", gen_count, 1);
      chk("g1_next_eval", eval_start, 1);
      chk("g1_done", done, 0);

      // Generation 2: shuffled order, duplicate index 7, out-of-range index.
      base = ss_cnt;
      for (int i = 0; i < POP; i++) if (i != 7) perm.push_back(i);
      for (int i = perm.size() - 1; i > 0; i--) begin
         r = $urandom_range(0, i);
         t = perm[i]; perm[i] = perm[r]; perm[r] = t;
      end
      send(7, 500);
      for (int j = 0; j < perm.size(); j++) begin
         if (j == 20) begin
            send(60, 77);
            chk("g2_err_index", err_index, 1);
         end
         if (j == 30) send(7, 3);
         if (j == perm.size() - 1) chk("g2_no_early_sort", ss_cnt, base);
         send(perm[j], $urandom_range(10, 4000));
      end
      chk("g2_entry7", sort_in[7*DW +: DW], 3);
      sort_respond("g2", 4, base);
      chk("g2_best7", best_index, 7);
      emit("g2", 4'b1111, cyc);
      tick();
      chk("g2_gen_count", gen_count, 2);

      // Generation 3: stalling breeder, then the generation limit ends the run.
      base = ss_cnt;
      for (int i = 0; i < POP; i++) send(i, 1000 - 7 * i);
      sort_respond("g3", 6, base);
      emit("g3", 4'b1001, cyc);
      tick();
      chk("g3_gen_count", gen_count, MAXG);
      chk("g3_done", done, 1);
      chk("g3_busy", busy, 0);
      chk("g3_eval_pulses", ev_cnt, MAXG);
      chk("g3_err_index_sticky", err_index, 1);
      chk("g3_queue_empty", expq.size(), 0);
      tick();
      chk("g3_done_hold", done, 1);
      run = 1'b0;
      tick();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);

      // Perfect individual in the first generation.
      run = 1'b1;
      tick();
      chk("p_eval_start", eval_start, 1);
      chk("p_err_cleared", err_index, 0);
      chk("p_gen_cleared", gen_count, 0);
      base = ss_cnt;
      for (int i = 0; i < POP; i++) send(i, (i == 5) ? 0 : 50 + i);
      sort_respond("p", 2, base);
      emit("p", 4'b1111, cyc);
      tick();
      chk("p_done", done, 1);
      chk("p_gen_count", gen_count, 1);
      run = 1'b0;
      tick();

      // Sorter never answers.
      run = 1'b1;
      tick();
      base = ss_cnt;
      for (int i = 0; i < POP; i++) send(i, 300 + i);
      chk("to_sort_start", sort_start, 1);
      n = 0;
      while (!err_timeout && n < 300) begin
         tick();
         n++;
      end
      chk("to_cycles", n, STO + 1);
      chk("to_err", err_timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_done", done, 0);
      chk("to_sort_once", ss_cnt, base + 1);
      base = ev_cnt;
      run = 1'b0;
      tick();
      run = 1'b1;
      repeat (3) tick();
      chk("to_stuck_busy", busy, 0);
      chk("to_stuck_eval", ev_cnt, base);

      // Reset out of FAULT, then reset in the middle of EMIT.
      reset = 1'b1;
      #1;
      check_zero("rst_fault");
      tick();
      reset = 1'b0;
      tick();
      base = ss_cnt;
      for (int i = 0; i < POP; i++) send(i, 700 - i);
      sort_respond("r", 1, base);
      par_ready = 1'b1;
      repeat (3) tick();
      chk("r_in_emit", par_valid, 1);
      reset = 1'b1;
      #1;
      check_zero("rst_emit");
      expq.delete();
      tick();
      reset = 1'b0;
      run = 1'b0;
      repeat (2) tick();
      chk("r_no_par_valid", par_valid, 0);
      par_ready = 1'b0;

      // Spurious sort_done while collecting is ignored.
      run = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) send(i, 20 + i);
      base = ss_cnt;
      for (int k = 0; k < POP; k++) sort_sorted[k*IW +: IW] = IW'(3);
      sort_done = 1'b1;
      tick();
      sort_done = 1'b0;
      tick();
      chk("sp_par_valid", par_valid, 0);
      chk("sp_busy", busy, 1);
      chk("sp_best_index", best_index, 0);
      chk("sp_best_dist", best_dist, 0);
      chk("sp_no_sort", ss_cnt, base);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
